// File: rtl/imem_boot_fetch.sv
// imem_boot_fetch: instruction memory for the single-cycle RISC-V core.
// A ready/valid boot-load port fills the array sequentially after reset or
// reload. A byte-addressed fetch port then returns a registered instruction
// together with its decoded fields and out-of-bounds/misalignment flags.
// Optional macro IMEM_PARITY_EN: stores an even-parity bit per word and
// flags a parity mismatch on fetch (NOP substituted).
module imem_boot_fetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 512,
  parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  input  logic            reload,
  input  logic            fetch_req,
  input  logic            fetch_stall,
  input  logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      func7,
  output logic            misalign_err,
  output logic            oob_err,
  output logic            load_ovf,
  output logic            running,
  output logic            parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic            load_ovf_q, load_ovf_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            misalign_q, misalign_d;
  logic            oob_q, oob_d;
  logic            parity_q, parity_d;

  logic [XLEN-1:0] mem [DEPTH];

  logic            ld_fire;
  logic [AW-1:0]   fetch_idx;
  logic [XLEN-1:0] mem_rd;
  logic            oob_hit;
  logic            misalign_hit;
  logic            parity_bad;

  // A reload in the same cycle as a handshake drops the load word.
  assign ld_fire      = ld_valid && (state_q == S_LOAD) && !reload;
  assign fetch_idx    = pc[AW+1:2];
  assign mem_rd       = mem[fetch_idx];
  assign oob_hit      = |pc[XLEN-1:AW+2];
  assign misalign_hit = |pc[1:0];

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  // Even-parity bit captured alongside each loaded word.
  always_ff @(posedge clk) begin
    if (ld_fire) par_mem[wptr_q] <= ^ld_data;
  end

  assign parity_bad = (^mem_rd) != par_mem[fetch_idx];
`else
  assign parity_bad = 1'b0;
`endif

  // Sequential boot-load write into the instruction array.
  // NOTE: the array has no reset; clearing it would need a multi-cycle
  // sweep or block RAM inference would be lost, and the loader overwrites it.
  always_ff @(posedge clk) begin
    if (ld_fire) mem[wptr_q] <= ld_data;
  end

  // Load-side next state: write pointer, overflow flag and FSM transition.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    load_ovf_d = load_ovf_q;
    if (reload) begin
      state_d    = S_LOAD;
      wptr_d     = '0;
      load_ovf_d = 1'b0;
    end else if (ld_fire) begin
      wptr_d = wptr_q + AW'(1);
      if (ld_last || (wptr_q == LAST_IDX)) state_d = S_RUN;
      if ((wptr_q == LAST_IDX) && !ld_last) load_ovf_d = 1'b1;
    end
  end

  // Fetch-side next state: registered instruction and single-cycle fault pulses.
  always_comb begin
    fetch_valid_d = fetch_valid_q;
    instr_d       = instr_q;
    misalign_d    = misalign_q;
    oob_d         = oob_q;
    parity_d      = parity_q;
    if (reload || (state_q == S_LOAD)) begin
      fetch_valid_d = 1'b0;
      misalign_d    = 1'b0;
      oob_d         = 1'b0;
      parity_d      = 1'b0;
    end else if (!fetch_stall) begin
      misalign_d = 1'b0;
      oob_d      = 1'b0;
      parity_d   = 1'b0;
      if (fetch_req) begin
        fetch_valid_d = 1'b1;
        if (oob_hit) begin
          instr_d = NOP_WORD;
          oob_d   = 1'b1;
        end else if (misalign_hit) begin
          instr_d    = NOP_WORD;
          misalign_d = 1'b1;
        end else if (parity_bad) begin
          instr_d  = NOP_WORD;
          parity_d = 1'b1;
        end else begin
          instr_d = mem_rd;
        end
      end else begin
        fetch_valid_d = 1'b0;
      end
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_LOAD;
      wptr_q        <= '0;
      load_ovf_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      instr_q       <= '0;
      misalign_q    <= 1'b0;
      oob_q         <= 1'b0;
      parity_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      load_ovf_q    <= load_ovf_d;
      fetch_valid_q <= fetch_valid_d;
      instr_q       <= instr_d;
      misalign_q    <= misalign_d;
      oob_q         <= oob_d;
      parity_q      <= parity_d;
    end
  end

  assign ld_ready     = (state_q == S_LOAD);
  assign running      = (state_q == S_RUN);
  assign load_ovf     = load_ovf_q;
  assign fetch_valid  = fetch_valid_q;
  assign instr        = instr_q;
  assign misalign_err = misalign_q;
  assign oob_err      = oob_q;
  assign parity_err   = parity_q;

  // Decode fields are fixed slices of the registered word.
  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign func3  = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign func7  = instr_q[31:25];

endmodule
